// File: rtl/lut_cfg_pkg.sv
// ----------------------------------------------------------------------------
// lut_cfg_pkg
// Shared types for the LUT configuration loader: mask width, mask type and
// the loader state encoding.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package lut_cfg_pkg;

  localparam int MASK_W = 8;

  typedef logic [MASK_W-1:0] mask_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    CHECK  = 2'd2,
    COMMIT = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/lut_cfg_loader.sv
// ----------------------------------------------------------------------------
// lut_cfg_loader
// Streams one 8-bit truth-table mask per LUT into shadow registers and
// commits the whole set atomically to the active mask outputs.
// Optional macro LUT_CFG_CHECKSUM_EN adds a trailing XOR checksum byte,
// a CHECK state and the cfg_err pulse output.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module lut_cfg_loader
  import lut_cfg_pkg::*;
#(
  parameter int NUM_LUTS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_start,
  input  logic [7:0]                 cfg_data,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  output logic [NUM_LUTS*MASK_W-1:0] masks,
  output logic                       cfg_busy,
  output logic                       cfg_done
`ifdef LUT_CFG_CHECKSUM_EN
  ,
  output logic                       cfg_err
`endif
);

  localparam int IDX_W = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LUTS - 1);

  state_t                     state_q,  state_d;
  logic [IDX_W-1:0]           idx_q,    idx_d;
  mask_t                      csum_q,   csum_d;
  mask_t [NUM_LUTS-1:0]       shadow_q, shadow_d;
  mask_t [NUM_LUTS-1:0]       masks_q,  masks_d;
`ifdef LUT_CFG_CHECKSUM_EN
  logic                       err_q,    err_d;
`endif

  logic xfer;

  // Handshake and status flags decode straight from the state register.
  assign cfg_ready = (state_q == LOAD) || (state_q == CHECK);
  assign cfg_busy  = (state_q != IDLE);
  assign cfg_done  = (state_q == COMMIT);
  assign masks     = masks_q;
  assign xfer      = cfg_valid & cfg_ready;
`ifdef LUT_CFG_CHECKSUM_EN
  assign cfg_err   = err_q;
`endif

  // Next-state, shadow capture, checksum accumulation and commit decision.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    csum_d   = csum_q;
    shadow_d = shadow_q;
    masks_d  = masks_q;
`ifdef LUT_CFG_CHECKSUM_EN
    err_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d = LOAD;
          idx_d   = '0;
          csum_d  = '0;
        end
      end
      LOAD: begin
        if (xfer) begin
          shadow_d[idx_q] = cfg_data;
          csum_d          = csum_q ^ cfg_data;
          if (idx_q == LAST_IDX) begin
            // Index saturates on the last LUT so it never leaves range.
`ifdef LUT_CFG_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = COMMIT;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef LUT_CFG_CHECKSUM_EN
      CHECK: begin
        if (xfer) begin
          if (cfg_data == csum_q) begin
            state_d = COMMIT;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
`endif
      COMMIT: begin
        masks_d = shadow_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      csum_q   <= '0;
      shadow_q <= '0;
      masks_q  <= '0;
`ifdef LUT_CFG_CHECKSUM_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      csum_q   <= csum_d;
      shadow_q <= shadow_d;
      masks_q  <= masks_d;
`ifdef LUT_CFG_CHECKSUM_EN
      err_q    <= err_d;
`endif
    end
  end

endmodule

`default_nettype wire
